// File: rtl/inertial_integrator_pkg.sv
// Shared types and constants for the balance-controller front end.
// Package name is segway_pkg so the rest of the controller can import it too.
package segway_pkg;

   // Calibration / run modes of the inertial integrator.
   typedef enum logic {
      CAL = 1'b0,
      RUN = 1'b1
   } state_e;

   // Accelerometer-to-pitch scale: pitch ~= az * ACC_GAIN >>> ACC_SHIFT.
   localparam int ACC_GAIN  = 327;
   localparam int ACC_SHIFT = 13;

   // Integrator: INT_W bits total, INT_FRAC fractional bits below ptch.
   localparam int INT_W    = 27;
   localparam int INT_FRAC = 11;

   // Number of samples averaged at start-up is 2**cal_shift(fast_sim).
   function automatic int cal_shift(input bit fast_sim);
      return fast_sim ? 4 : 10;
   endfunction

endpackage

// File: rtl/inertial_integrator_gyro_cal.sv
// Gyro offset calibration: averages the first 2**CAL_SHIFT rate samples
// after reset and holds the result as the gyro offset.
module gyro_cal
   import segway_pkg::*;
#(
   parameter int CAL_SHIFT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_vld,
   input  logic [15:0] i_rt_raw,
   output logic [15:0] o_offset,
   output logic        o_fire,
   output logic        o_done
);

   localparam int SUM_W = 16 + CAL_SHIFT;

   logic signed [SUM_W-1:0]     r_sum;
   logic        [CAL_SHIFT-1:0] r_cnt;
   logic        [15:0]          r_offset;
   logic                        r_done;

   logic signed [SUM_W-1:0]     w_rt_ext;
   logic signed [SUM_W-1:0]     w_sum_next;
   logic                        w_take;

   assign w_take     = i_vld && !r_done;
   assign w_rt_ext   = {{CAL_SHIFT{i_rt_raw[15]}}, i_rt_raw};
   assign w_sum_next = r_sum + w_rt_ext;
   // The last sample of the window is the one seen with the counter all-ones.
   assign o_fire     = w_take && (r_cnt == '1);
   assign o_offset   = r_offset;
   assign o_done     = r_done;

   // Accumulate samples; on the last one latch the average (sum >>> CAL_SHIFT).
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (!rst_n) begin
         r_sum    <= '0;
         r_cnt    <= '0;
         r_offset <= '0;
         r_done   <= 1'b0;
      end else if (w_take) begin
         r_sum <= w_sum_next;
         r_cnt <= r_cnt + 1'b1;
         if (o_fire) begin
            // Bits [CAL_SHIFT+15:CAL_SHIFT] are the low 16 bits of sum >>> CAL_SHIFT.
            r_offset <= w_sum_next[CAL_SHIFT+15:CAL_SHIFT];
            r_done   <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/inertial_integrator.sv
// Inertial integrator: offset-compensates and integrates gyro pitch rate,
// pulling the integral toward accelerometer-derived pitch by a fixed step
// per sample to cancel drift.
// Optional feature macro: GYRO_CAL_EN -- when defined, the gyro offset is
// averaged at start-up (CAL state); otherwise PTCH_RT_OFFSET is used.
module inertial_integrator
   import segway_pkg::*;
#(
   parameter bit          fast_sim       = 1'b1,
   parameter logic [15:0] PTCH_RT_OFFSET = 16'h0050,
   parameter logic [15:0] AZ_OFFSET      = 16'h00A0,
   parameter int          FUSION_GAIN    = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        vld,
   input  logic [15:0] ptch_rt_raw,
   input  logic [15:0] AZ_raw,
   output logic [15:0] ptch,
   output logic [15:0] ptch_rt,
   output logic        ptch_vld,
   output logic        cal_done
);

   localparam logic signed [25:0]      ACC_GAIN_S = 26'(ACC_GAIN);
   localparam logic signed [INT_W-1:0] FUS_POS    = INT_W'(FUSION_GAIN);
   localparam logic signed [INT_W-1:0] FUS_NEG    = -FUS_POS;

   logic signed [INT_W-1:0] r_int;
   logic        [15:0]      r_ptch;
   logic        [15:0]      r_ptch_rt;
   logic                    r_ptch_vld;

   logic        [15:0]      w_offset;
   logic                    w_run;
   logic        [15:0]      w_rt_comp;
   logic        [15:0]      w_az_comp;
   logic signed [25:0]      w_az_ext;
   logic signed [25:0]      w_acc_prod;
   logic signed [25:0]      w_acc_ptch;
   logic signed [25:0]      w_ptch_ext;
   logic signed [INT_W-1:0] w_rt_ext;
   logic signed [INT_W-1:0] w_fus;
   logic signed [INT_W-1:0] w_int_next;
   logic                    w_update;

`ifdef GYRO_CAL_EN
   localparam int CAL_SHIFT = cal_shift(fast_sim);

   state_e r_state;
   state_e w_state_next;
   logic   w_cal_fire;

   gyro_cal #(
      .CAL_SHIFT (CAL_SHIFT)
   ) u_gyro_cal (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_vld    (vld && (r_state == CAL)),
      .i_rt_raw (ptch_rt_raw),
      .o_offset (w_offset),
      .o_fire   (w_cal_fire),
      .o_done   (cal_done)
   );

   // State register: reset always restarts calibration.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= CAL;
      else        r_state <= w_state_next;
   end

   // Next state: leave CAL on the edge that captures the last calibration sample.
   always_comb begin
      // NOTE: default assignment first so no path leaves the variable unassigned
      // (which would infer a latch).
      w_state_next = r_state;
      if ((r_state == CAL) && w_cal_fire) w_state_next = RUN;
   end

   assign w_run = (r_state == RUN);
`else
   assign w_offset = PTCH_RT_OFFSET;
   assign w_run    = 1'b1;
   assign cal_done = 1'b1;
`endif

   // Compensated rate and accelerometer pitch estimate.
   assign w_rt_comp  = ptch_rt_raw - w_offset;
   assign w_az_comp  = AZ_raw - AZ_OFFSET;
   assign w_az_ext   = {{10{w_az_comp[15]}}, w_az_comp};
   assign w_acc_prod = w_az_ext * ACC_GAIN_S;
   assign w_acc_ptch = w_acc_prod >>> ACC_SHIFT;
   assign w_ptch_ext = {{10{r_ptch[15]}}, r_ptch};

   // Fusion step: nudge the integral one fixed step toward accelerometer pitch.
   always_comb begin
      w_fus = '0;
      if (w_acc_ptch > w_ptch_ext)      w_fus = FUS_POS;
      else if (w_acc_ptch < w_ptch_ext) w_fus = FUS_NEG;
   end

   assign w_rt_ext   = {{(INT_W-16){w_rt_comp[15]}}, w_rt_comp};
   assign w_int_next = r_int - w_rt_ext + w_fus;
   assign w_update   = vld && w_run;

   // Integrator and output registers, all advanced by the same accepted sample.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_int      <= '0;
         r_ptch     <= '0;
         r_ptch_rt  <= '0;
         r_ptch_vld <= 1'b0;
      end else begin
         r_ptch_vld <= w_update;
         if (w_update) begin
            r_int     <= w_int_next;
            r_ptch    <= w_int_next[INT_W-1:INT_FRAC];
            r_ptch_rt <= w_rt_comp;
         end
      end
   end

   assign ptch     = r_ptch;
   assign ptch_rt  = r_ptch_rt;
   assign ptch_vld = r_ptch_vld;

endmodule

// File: tb/tb_inertial_integrator.sv
// Directed bench for inertial_integrator: table-driven single samples plus
// hand-written sequences for reset, calibration, fusion convergence and
// back-to-back strobes. Honors GYRO_CAL_EN when it is defined.
module tb_inertial_integrator;

   logic        clk;
   logic        rst_n;
   logic        vld;
   logic [15:0] ptch_rt_raw;
   logic [15:0] AZ_raw;
   logic [15:0] ptch;
   logic [15:0] ptch_rt;
   logic        ptch_vld;
   logic        cal_done;

   int checks   = 0;
   int failures = 0;

   inertial_integrator #(
      .fast_sim (1'b1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .vld         (vld),
      .ptch_rt_raw (ptch_rt_raw),
      .AZ_raw      (AZ_raw),
      .ptch        (ptch),
      .ptch_rt     (ptch_rt),
      .ptch_vld    (ptch_vld),
      .cal_done    (cal_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] rt_raw;
      logic [15:0] az_raw;
      logic [15:0] exp_ptch;
      logic [15:0] exp_ptch_rt;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive one sample at a negedge, step past the posedge, leave vld low.
   task automatic apply(input logic [15:0] rt, input logic [15:0] az);
      vld         = 1'b1;
      ptch_rt_raw = rt;
      AZ_raw      = az;
      @(negedge clk);
      vld = 1'b0;
   endtask

`ifdef GYRO_CAL_EN
   // Feed 16 samples of one value; cal_done must rise only on the last.
   task automatic calibrate(input logic [15:0] rt);
      for (int i = 0; i < 16; i++) begin
         apply(rt, 16'h00A0);
         check($sformatf("cal_vld_low_%0d", i), {31'd0, ptch_vld}, 32'd0);
         check($sformatf("cal_done_%0d", i), {31'd0, cal_done}, (i == 15) ? 32'd1 : 32'd0);
      end
   endtask
`endif

   // Hold reset for two edges with vld toggling, then release.
   task automatic do_reset(input logic calib);
      rst_n       = 1'b0;
      ptch_rt_raw = 16'h1234;
      AZ_raw      = 16'h5678;
      vld         = 1'b1;
      @(negedge clk);
      vld = 1'b0;
      @(negedge clk);
      vld = 1'b1;
      check("rst_ptch", {16'd0, ptch}, 32'd0);
      check("rst_ptch_rt", {16'd0, ptch_rt}, 32'd0);
      check("rst_ptch_vld", {31'd0, ptch_vld}, 32'd0);
`ifdef GYRO_CAL_EN
      check("rst_cal_done", {31'd0, cal_done}, 32'd0);
`else
      check("rst_cal_done", {31'd0, cal_done}, 32'd1);
`endif
      vld   = 1'b0;
      rst_n = 1'b1;
`ifdef GYRO_CAL_EN
      if (calib) calibrate(16'h0050);
`else
      if (calib) check("no_cal_done", {31'd0, cal_done}, 32'd1);
`endif
   endtask

   initial begin
      int vcount;

      // Offset 0x50, AZ offset 0xA0; expected values worked out by hand.
      vecs[0] = '{16'hF850, 16'h00A0, 16'h0001, 16'hF800}; // int 2048
      vecs[1] = '{16'hF850, 16'h00A0, 16'h0001, 16'hF800}; // fus -1024 -> 3072
      vecs[2] = '{16'h0050, 16'h00A0, 16'h0001, 16'h0000}; // 2048
      vecs[3] = '{16'h0050, 16'h00A0, 16'h0000, 16'h0000}; // 1024
      vecs[4] = '{16'h0050, 16'h00A0, 16'h0000, 16'h0000}; // equal: 1024
      vecs[5] = '{16'h0850, 16'h00A0, 16'hFFFF, 16'h0800}; // -1024
      vecs[6] = '{16'h0050, 16'h0000, 16'hFFFF, 16'h0000}; // acc -7: -2048
      vecs[7] = '{16'h0050, 16'h0000, 16'hFFFE, 16'h0000}; // -3072

      rst_n       = 1'b0;
      vld         = 1'b0;
      ptch_rt_raw = '0;
      AZ_raw      = '0;
      @(negedge clk);

`ifdef GYRO_CAL_EN
      // Calibration against 0x60, then a 0x60 sample compensates to zero.
      do_reset(1'b0);
      calibrate(16'h0060);
      apply(16'h0060, 16'h00A0);
      check("postcal_ptch_rt", {16'd0, ptch_rt}, 32'd0);
      check("postcal_ptch", {16'd0, ptch}, 32'd0);
      check("postcal_vld", {31'd0, ptch_vld}, 32'd1);
`endif

      // Table-driven single samples, each followed by an idle cycle.
      do_reset(1'b1);
      for (int i = 0; i < 8; i++) begin
         apply(vecs[i].rt_raw, vecs[i].az_raw);
         check($sformatf("vec%0d_ptch", i), {16'd0, ptch}, {16'd0, vecs[i].exp_ptch});
         check($sformatf("vec%0d_ptch_rt", i), {16'd0, ptch_rt}, {16'd0, vecs[i].exp_ptch_rt});
         check($sformatf("vec%0d_vld", i), {31'd0, ptch_vld}, 32'd1);
         @(negedge clk);
         check($sformatf("vec%0d_vld_drop", i), {31'd0, ptch_vld}, 32'd0);
         check($sformatf("vec%0d_hold", i), {16'd0, ptch}, {16'd0, vecs[i].exp_ptch});
      end

      // Back-to-back: 8 consecutive strobes toward acc_ptch=163, +1024 each.
      do_reset(1'b1);
      vcount = 0;
      vld         = 1'b1;
      ptch_rt_raw = 16'h0050;
      AZ_raw      = 16'h10A0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (ptch_vld) vcount++;
         check($sformatf("b2b_ptch_%0d", i), {16'd0, ptch}, 32'(i / 2));
      end
      check("b2b_vld_count", 32'(vcount), 32'd8);

      // Continue to 325 samples total: int = 332800 -> ptch 162.
      repeat (317) @(negedge clk);
      check("fuse_325", {16'd0, ptch}, 32'd162);
      @(negedge clk);
      check("fuse_326", {16'd0, ptch}, 32'd163);
      // At equality the fusion step is zero and rate is zero: ptch holds.
      repeat (4) @(negedge clk);
      check("fuse_hold", {16'd0, ptch}, 32'd163);
      check("fuse_vld", {31'd0, ptch_vld}, 32'd1);
      vld = 1'b0;
      @(negedge clk);
      check("fuse_vld_drop", {31'd0, ptch_vld}, 32'd0);

      // One-cycle reset mid-RUN with vld asserted clears everything.
      rst_n       = 1'b0;
      vld         = 1'b1;
      ptch_rt_raw = 16'hF850;
      AZ_raw      = 16'h00A0;
      @(negedge clk);
      rst_n = 1'b1;
      vld   = 1'b0;
      check("midrst_ptch", {16'd0, ptch}, 32'd0);
      check("midrst_ptch_rt", {16'd0, ptch_rt}, 32'd0);
      check("midrst_vld", {31'd0, ptch_vld}, 32'd0);
`ifdef GYRO_CAL_EN
      check("midrst_cal_done", {31'd0, cal_done}, 32'd0);
      calibrate(16'h0050);
`else
      check("midrst_cal_done", {31'd0, cal_done}, 32'd1);
`endif
      // Integrator restarted from zero: the first table vector repeats.
      apply(16'hF850, 16'h00A0);
      check("restart_ptch", {16'd0, ptch}, 32'd1);
      check("restart_ptch_rt", {16'd0, ptch_rt}, 32'h0000F800);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
